// File: rtl/ctrl_sequencer.sv
// Hardwired fetch/execute control unit for the single-bus datapath.
// Optional feature macro SINGLE_STEP_EN: adds a Step input and a PAUSE state between instructions.
module ctrl_sequencer #(
    parameter int OP_W  = 5,
    parameter int ALU_W = 12
) (
    input  logic             clk,
    input  logic             clr,
`ifdef SINGLE_STEP_EN
    input  logic             Step,
`endif
    input  logic [31:0]      IR,
    input  logic             CON_FF,
    input  logic             Mem_ready,
    output logic             PCout,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             MDRout,
    output logic             Cout,
    output logic             BAout,
    output logic             Rout,
    output logic             PCin,
    output logic             MARin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             Rin,
    output logic             CONin,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             IncPC,
    output logic             Read,
    output logic             Write,
    output logic [ALU_W-1:0] ALUControl,
    output logic             Run,
    output logic             Illegal
);

    typedef enum logic [3:0] {
        T0, T1, T2, T3, T4, T5, T6, T7, HALT
`ifdef SINGLE_STEP_EN
        , PAUSE
`endif
    } state_t;

`ifdef SINGLE_STEP_EN
    localparam state_t DONE_ST = PAUSE;
`else
    localparam state_t DONE_ST = T0;
`endif

    localparam logic [OP_W-1:0] OP_LD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ST   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_ADD  = OP_W'(9);
    localparam logic [OP_W-1:0] OP_ROL  = OP_W'(16);
    localparam logic [OP_W-1:0] OP_BR   = OP_W'(19);
    localparam logic [OP_W-1:0] OP_NOP  = OP_W'(26);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(27);

    state_t          state;
    logic [OP_W-1:0] opcode;
    logic            is_alu, is_addi, is_ld, is_st, is_br, is_mem, is_legal;
    logic            unused_ir;
    logic [ALU_W-1:0] alu_onehot;

    assign opcode    = IR[31 -: OP_W];
    assign unused_ir = ^IR[31-OP_W:0];

    assign is_alu   = (opcode >= OP_ADD) && (opcode <= OP_ROL);
    assign is_addi  = (opcode == OP_ADDI);
    assign is_ld    = (opcode == OP_LD);
    assign is_st    = (opcode == OP_ST);
    assign is_br    = (opcode == OP_BR);
    assign is_mem   = is_ld || is_st;
    assign is_legal = is_alu || is_addi || is_mem || is_br ||
                      (opcode == OP_NOP) || (opcode == OP_HALT);

    // R-type opcodes are contiguous from add, so the one-hot bit is the offset from add.
    assign alu_onehot = ALU_W'(1) << (opcode - OP_ADD);

`ifdef SINGLE_STEP_EN
    logic armed;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= DONE_ST;
            Illegal <= 1'b0;
`ifdef SINGLE_STEP_EN
            armed   <= 1'b0;
`endif
        end else begin
`ifdef SINGLE_STEP_EN
            // A step is consumed once; Step must drop before another is accepted.
            if (!Step)
                armed <= 1'b1;
            else if (state == PAUSE && armed)
                armed <= 1'b0;
`endif
            case (state)
                T0: state <= T1;
                T1: if (Mem_ready) state <= T2;
                T2: state <= T3;
                T3: begin
                    if (!is_legal)
                        Illegal <= 1'b1;
                    if (opcode == OP_HALT)
                        state <= HALT;
                    else if (is_alu || is_addi || is_mem || is_br)
                        state <= T4;
                    else
                        state <= DONE_ST;
                end
                T4: state <= T5;
                T5: state <= (is_mem || is_br) ? T6 : DONE_ST;
                T6: begin
                    if (is_st)
                        state <= T7;
                    else if (is_ld) begin
                        if (Mem_ready) state <= T7;
                    end else
                        state <= DONE_ST;
                end
                T7: begin
                    if (!is_st || Mem_ready)
                        state <= DONE_ST;
                end
                HALT: state <= HALT;
`ifdef SINGLE_STEP_EN
                PAUSE: if (Step && armed) state <= T0;
`endif
                default: state <= T0;
            endcase
        end
    end

    // Strobes are decoded from the state and the live IR: IR is loaded on the
    // T2->T3 edge, so T3 cannot be precomputed. Reset gates them off at once.
    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
        Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
        PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0;
        Zin = 1'b0; Rin = 1'b0; CONin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
        IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        ALUControl = '0;
        Run = 1'b1;
        if (clr) begin
            case (state)
                T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
                T1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
                T2: begin MDRout = 1'b1; IRin = 1'b1; end
                T3: begin
                    if (is_alu || is_addi) begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end else if (is_mem) begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end else if (is_br) begin
                        Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
                    end
                end
                T4: begin
                    if (is_alu) begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1; ALUControl = alu_onehot;
                    end else if (is_addi || is_mem) begin
                        Cout = 1'b1; Zin = 1'b1; ALUControl[0] = 1'b1;
                    end else if (is_br) begin
                        PCout = 1'b1; Yin = 1'b1;
                    end
                end
                T5: begin
                    if (is_alu || is_addi) begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (is_mem) begin
                        Zlowout = 1'b1; MARin = 1'b1;
                    end else if (is_br) begin
                        Cout = 1'b1; Zin = 1'b1; ALUControl[0] = 1'b1;
                    end
                end
                T6: begin
                    if (is_ld) begin
                        Read = 1'b1; MDRin = 1'b1;
                    end else if (is_st) begin
                        Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                    end else if (is_br && CON_FF) begin
                        Zlowout = 1'b1; PCin = 1'b1;
                    end
                end
                T7: begin
                    if (is_ld) begin
                        MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (is_st) begin
                        Write = 1'b1;
                    end
                end
                HALT: Run = 1'b0;
`ifdef SINGLE_STEP_EN
                PAUSE: Run = 1'b0;
`endif
                default: Run = 1'b1;
            endcase
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed, table-driven bench for ctrl_sequencer; SINGLE_STEP_EN selects the single-step flow.
module tb_ctrl_sequencer;

    localparam logic [20:0] B_PCOUT  = 21'h100000;
    localparam logic [20:0] B_ZLOW   = 21'h080000;
    localparam logic [20:0] B_MDROUT = 21'h020000;
    localparam logic [20:0] B_COUT   = 21'h010000;
    localparam logic [20:0] B_BAOUT  = 21'h008000;
    localparam logic [20:0] B_ROUT   = 21'h004000;
    localparam logic [20:0] B_PCIN   = 21'h002000;
    localparam logic [20:0] B_MARIN  = 21'h001000;
    localparam logic [20:0] B_MDRIN  = 21'h000800;
    localparam logic [20:0] B_IRIN   = 21'h000400;
    localparam logic [20:0] B_YIN    = 21'h000200;
    localparam logic [20:0] B_ZIN    = 21'h000100;
    localparam logic [20:0] B_RIN    = 21'h000080;
    localparam logic [20:0] B_CONIN  = 21'h000040;
    localparam logic [20:0] B_GRA    = 21'h000020;
    localparam logic [20:0] B_GRB    = 21'h000010;
    localparam logic [20:0] B_GRC    = 21'h000008;
    localparam logic [20:0] B_INCPC  = 21'h000004;
    localparam logic [20:0] B_READ   = 21'h000002;
    localparam logic [20:0] B_WRITE  = 21'h000001;

    localparam logic [20:0] F_T0 = B_PCOUT | B_MARIN | B_INCPC | B_ZIN;
    localparam logic [20:0] F_T1 = B_ZLOW | B_PCIN | B_READ | B_MDRIN;
    localparam logic [20:0] F_T2 = B_MDROUT | B_IRIN;

    localparam logic [31:0] IR_ADD  = 32'h4A920000;
    localparam logic [31:0] IR_SHL  = 32'h72920000;
    localparam logic [31:0] IR_ROL  = 32'h82920000;
    localparam logic [31:0] IR_ADDI = 32'h08A40005;
    localparam logic [31:0] IR_LD   = 32'h01080010;
    localparam logic [31:0] IR_ST   = 32'h11080008;
    localparam logic [31:0] IR_BR   = 32'h98800020;
    localparam logic [31:0] IR_NOP  = 32'hD0000000;
    localparam logic [31:0] IR_HALT = 32'hD8000000;
    localparam logic [31:0] IR_BAD  = 32'hF8000000;

    typedef struct {
        string       name;
        logic [31:0] ir;
        logic        con;
        logic        mem;
        logic [20:0] strb;
        logic [11:0] alu;
        logic        run;
    } vec_t;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic [31:0] IR = '0;
    logic CON_FF = 1'b0;
    logic Mem_ready = 1'b0;
`ifdef SINGLE_STEP_EN
    logic Step = 1'b0;
`endif
    logic PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout;
    logic PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin;
    logic Gra, Grb, Grc, IncPC, Read, Write;
    logic [11:0] ALUControl;
    logic Run, Illegal;
    logic [20:0] strb_obs;

    int checks = 0;
    int fails = 0;
    logic exp_illegal = 1'b0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    assign strb_obs = {PCout, Zlowout, Zhighout, MDRout, Cout, BAout, Rout,
                       PCin, MARin, MDRin, IRin, Yin, Zin, Rin, CONin,
                       Gra, Grb, Grc, IncPC, Read, Write};

    ctrl_sequencer #(.OP_W(5), .ALU_W(12)) dut (
        .clk(clk), .clr(clr),
`ifdef SINGLE_STEP_EN
        .Step(Step),
`endif
        .IR(IR), .CON_FF(CON_FF), .Mem_ready(Mem_ready),
        .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
        .Cout(Cout), .BAout(BAout), .Rout(Rout),
        .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .Zin(Zin), .Rin(Rin), .CONin(CONin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .IncPC(IncPC), .Read(Read), .Write(Write),
        .ALUControl(ALUControl), .Run(Run), .Illegal(Illegal)
    );

    task automatic applyStimulus(input vec_t v);
        IR = v.ir;
        CON_FF = v.con;
        Mem_ready = v.mem;
    endtask

    task automatic checkOutput(input vec_t v);
        checks++;
        if (strb_obs !== v.strb) begin
            fails++;
            $display("[TB] FAIL %s strobes: got %h expected %h", v.name, strb_obs, v.strb);
        end
        checks++;
        if (ALUControl !== v.alu) begin
            fails++;
            $display("[TB] FAIL %s ALUControl: got %h expected %h", v.name, ALUControl, v.alu);
        end
        checks++;
        if (Run !== v.run) begin
            fails++;
            $display("[TB] FAIL %s Run: got %b expected %b", v.name, Run, v.run);
        end
        checks++;
        if (Illegal !== exp_illegal) begin
            fails++;
            $display("[TB] FAIL %s Illegal: got %b expected %b", v.name, Illegal, exp_illegal);
        end
    endtask

    task automatic runVec(input vec_t v);
        applyStimulus(v);
        #1;
        checkOutput(v);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkVec(input string n, input logic [31:0] ir, input logic con,
                                   input logic mem, input logic [20:0] s, input logic [11:0] a,
                                   input logic run);
        vec_t v;
        v.name = n; v.ir = ir; v.con = con; v.mem = mem;
        v.strb = s; v.alu = a; v.run = run;
        return v;
    endfunction

    task automatic pushVec(input string n, input logic [31:0] ir, input logic con,
                           input logic mem, input logic [20:0] s, input logic [11:0] a);
        vecs.push_back(mkVec(n, ir, con, mem, s, a, 1'b1));
    endtask

    task automatic pushFetch(input string n, input logic [31:0] ir);
        pushVec({n, " T0"}, ir, 1'b0, 1'b1, F_T0, 12'h000);
        pushVec({n, " T1"}, ir, 1'b0, 1'b1, F_T1, 12'h000);
        pushVec({n, " T2"}, ir, 1'b0, 1'b1, F_T2, 12'h000);
    endtask

    task automatic stepCheck(input string n, input logic [31:0] ir, input logic con,
                             input logic mem, input logic [20:0] s, input logic [11:0] a,
                             input logic run);
        runVec(mkVec(n, ir, con, mem, s, a, run));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput(mkVec("reset", 32'h0, 1'b0, 1'b0, 21'h0, 12'h000, 1'b1));
        clr = 1'b1;

`ifdef SINGLE_STEP_EN
        // Held in PAUSE until a Step pulse; one instruction per pulse.
        for (int i = 0; i < 3; i++)
            stepCheck("pause idle", IR_ADD, 1'b0, 1'b1, 21'h0, 12'h000, 1'b0);
        Step = 1'b1;
        stepCheck("pause step", IR_ADD, 1'b0, 1'b1, 21'h0, 12'h000, 1'b0);
        Step = 1'b0;
        stepCheck("step add T0", IR_ADD, 1'b0, 1'b1, F_T0, 12'h000, 1'b1);
        stepCheck("step add T1", IR_ADD, 1'b0, 1'b1, F_T1, 12'h000, 1'b1);
        stepCheck("step add T2", IR_ADD, 1'b0, 1'b1, F_T2, 12'h000, 1'b1);
        stepCheck("step add T3", IR_ADD, 1'b0, 1'b1, B_GRB | B_ROUT | B_YIN, 12'h000, 1'b1);
        stepCheck("step add T4", IR_ADD, 1'b0, 1'b1, B_GRC | B_ROUT | B_ZIN, 12'h001, 1'b1);
        stepCheck("step add T5", IR_ADD, 1'b0, 1'b1, B_ZLOW | B_GRA | B_RIN, 12'h000, 1'b1);
        stepCheck("pause after add", IR_ADD, 1'b0, 1'b1, 21'h0, 12'h000, 1'b0);
        Step = 1'b1;
        stepCheck("pause step2", IR_NOP, 1'b0, 1'b1, 21'h0, 12'h000, 1'b0);
        stepCheck("step nop T0", IR_NOP, 1'b0, 1'b1, F_T0, 12'h000, 1'b1);
        stepCheck("step nop T1", IR_NOP, 1'b0, 1'b1, F_T1, 12'h000, 1'b1);
        stepCheck("step nop T2", IR_NOP, 1'b0, 1'b1, F_T2, 12'h000, 1'b1);
        stepCheck("step nop T3", IR_NOP, 1'b0, 1'b1, 21'h0, 12'h000, 1'b1);
        for (int i = 0; i < 3; i++)
            stepCheck("pause step held", IR_NOP, 1'b0, 1'b1, 21'h0, 12'h000, 1'b0);
        Step = 1'b0;
`else
        // Back-to-back instructions with Mem_ready high, so every wait is one cycle.
        pushFetch("add", IR_ADD);
        pushVec("add T3", IR_ADD, 1'b0, 1'b1, B_GRB | B_ROUT | B_YIN, 12'h000);
        pushVec("add T4", IR_ADD, 1'b0, 1'b1, B_GRC | B_ROUT | B_ZIN, 12'h001);
        pushVec("add T5", IR_ADD, 1'b0, 1'b1, B_ZLOW | B_GRA | B_RIN, 12'h000);
        pushFetch("shl", IR_SHL);
        pushVec("shl T3", IR_SHL, 1'b0, 1'b1, B_GRB | B_ROUT | B_YIN, 12'h000);
        pushVec("shl T4", IR_SHL, 1'b0, 1'b1, B_GRC | B_ROUT | B_ZIN, 12'h020);
        pushVec("shl T5", IR_SHL, 1'b0, 1'b1, B_ZLOW | B_GRA | B_RIN, 12'h000);
        pushFetch("rol", IR_ROL);
        pushVec("rol T3", IR_ROL, 1'b0, 1'b1, B_GRB | B_ROUT | B_YIN, 12'h000);
        pushVec("rol T4", IR_ROL, 1'b0, 1'b1, B_GRC | B_ROUT | B_ZIN, 12'h080);
        pushVec("rol T5", IR_ROL, 1'b0, 1'b1, B_ZLOW | B_GRA | B_RIN, 12'h000);
        pushFetch("addi", IR_ADDI);
        pushVec("addi T3", IR_ADDI, 1'b0, 1'b1, B_GRB | B_ROUT | B_YIN, 12'h000);
        pushVec("addi T4", IR_ADDI, 1'b0, 1'b1, B_COUT | B_ZIN, 12'h001);
        pushVec("addi T5", IR_ADDI, 1'b0, 1'b1, B_ZLOW | B_GRA | B_RIN, 12'h000);
        pushFetch("st", IR_ST);
        pushVec("st T3", IR_ST, 1'b0, 1'b1, B_GRB | B_BAOUT | B_YIN, 12'h000);
        pushVec("st T4", IR_ST, 1'b0, 1'b1, B_COUT | B_ZIN, 12'h001);
        pushVec("st T5", IR_ST, 1'b0, 1'b1, B_ZLOW | B_MARIN, 12'h000);
        pushVec("st T6", IR_ST, 1'b0, 1'b1, B_GRA | B_ROUT | B_MDRIN, 12'h000);
        pushVec("st T7", IR_ST, 1'b0, 1'b1, B_WRITE, 12'h000);
        pushFetch("br0", IR_BR);
        pushVec("br0 T3", IR_BR, 1'b0, 1'b1, B_GRA | B_ROUT | B_CONIN, 12'h000);
        pushVec("br0 T4", IR_BR, 1'b0, 1'b1, B_PCOUT | B_YIN, 12'h000);
        pushVec("br0 T5", IR_BR, 1'b0, 1'b1, B_COUT | B_ZIN, 12'h001);
        pushVec("br0 T6", IR_BR, 1'b0, 1'b1, 21'h0, 12'h000);
        pushFetch("br1", IR_BR);
        pushVec("br1 T3", IR_BR, 1'b1, 1'b1, B_GRA | B_ROUT | B_CONIN, 12'h000);
        pushVec("br1 T4", IR_BR, 1'b1, 1'b1, B_PCOUT | B_YIN, 12'h000);
        pushVec("br1 T5", IR_BR, 1'b1, 1'b1, B_COUT | B_ZIN, 12'h001);
        pushVec("br1 T6", IR_BR, 1'b1, 1'b1, B_ZLOW | B_PCIN, 12'h000);
        pushFetch("nop", IR_NOP);
        pushVec("nop T3", IR_NOP, 1'b0, 1'b1, 21'h0, 12'h000);

        foreach (vecs[i])
            runVec(vecs[i]);

        // ld with the fetch wait and the operand wait both stretched.
        stepCheck("ld T0", IR_LD, 1'b0, 1'b1, F_T0, 12'h000, 1'b1);
        for (int i = 0; i < 2; i++)
            stepCheck("ld T1 stall", IR_LD, 1'b0, 1'b0, F_T1, 12'h000, 1'b1);
        stepCheck("ld T1 ready", IR_LD, 1'b0, 1'b1, F_T1, 12'h000, 1'b1);
        stepCheck("ld T2", IR_LD, 1'b0, 1'b1, F_T2, 12'h000, 1'b1);
        stepCheck("ld T3", IR_LD, 1'b0, 1'b1, B_GRB | B_BAOUT | B_YIN, 12'h000, 1'b1);
        stepCheck("ld T4", IR_LD, 1'b0, 1'b1, B_COUT | B_ZIN, 12'h001, 1'b1);
        stepCheck("ld T5", IR_LD, 1'b0, 1'b1, B_ZLOW | B_MARIN, 12'h000, 1'b1);
        for (int i = 0; i < 3; i++)
            stepCheck("ld T6 stall", IR_LD, 1'b0, 1'b0, B_READ | B_MDRIN, 12'h000, 1'b1);
        stepCheck("ld T6 ready", IR_LD, 1'b0, 1'b1, B_READ | B_MDRIN, 12'h000, 1'b1);
        stepCheck("ld T7", IR_LD, 1'b0, 1'b0, B_MDROUT | B_GRA | B_RIN, 12'h000, 1'b1);

        // Undefined opcode behaves as nop and leaves Illegal set.
        stepCheck("bad T0", IR_BAD, 1'b0, 1'b1, F_T0, 12'h000, 1'b1);
        stepCheck("bad T1", IR_BAD, 1'b0, 1'b1, F_T1, 12'h000, 1'b1);
        stepCheck("bad T2", IR_BAD, 1'b0, 1'b1, F_T2, 12'h000, 1'b1);
        stepCheck("bad T3", IR_BAD, 1'b0, 1'b1, 21'h0, 12'h000, 1'b1);
        exp_illegal = 1'b1;
        stepCheck("after bad T0", IR_NOP, 1'b0, 1'b1, F_T0, 12'h000, 1'b1);
        stepCheck("after bad T1", IR_NOP, 1'b0, 1'b1, F_T1, 12'h000, 1'b1);
        stepCheck("after bad T2", IR_NOP, 1'b0, 1'b1, F_T2, 12'h000, 1'b1);
        stepCheck("after bad T3", IR_NOP, 1'b0, 1'b1, 21'h0, 12'h000, 1'b1);

        // Reset pulled in the middle of T4 of an add.
        stepCheck("abort T0", IR_ADD, 1'b0, 1'b1, F_T0, 12'h000, 1'b1);
        stepCheck("abort T1", IR_ADD, 1'b0, 1'b1, F_T1, 12'h000, 1'b1);
        stepCheck("abort T2", IR_ADD, 1'b0, 1'b1, F_T2, 12'h000, 1'b1);
        stepCheck("abort T3", IR_ADD, 1'b0, 1'b1, B_GRB | B_ROUT | B_YIN, 12'h000, 1'b1);
        applyStimulus(mkVec("abort T4", IR_ADD, 1'b0, 1'b1, 21'h0, 12'h000, 1'b1));
        #1;
        checkOutput(mkVec("abort T4", IR_ADD, 1'b0, 1'b1, B_GRC | B_ROUT | B_ZIN, 12'h001, 1'b1));
        #2;
        clr = 1'b0;
        exp_illegal = 1'b0;
        #1;
        checkOutput(mkVec("abort async", IR_ADD, 1'b0, 1'b1, 21'h0, 12'h000, 1'b1));
        @(posedge clk);
        #1;
        checkOutput(mkVec("abort held", IR_ADD, 1'b0, 1'b1, 21'h0, 12'h000, 1'b1));
        clr = 1'b1;
        stepCheck("restart T0", IR_ADD, 1'b0, 1'b1, F_T0, 12'h000, 1'b1);
        stepCheck("restart T1", IR_ADD, 1'b0, 1'b1, F_T1, 12'h000, 1'b1);
        stepCheck("restart T2", IR_ADD, 1'b0, 1'b1, F_T2, 12'h000, 1'b1);
        stepCheck("restart T3", IR_ADD, 1'b0, 1'b1, B_GRB | B_ROUT | B_YIN, 12'h000, 1'b1);
        stepCheck("restart T4", IR_ADD, 1'b0, 1'b1, B_GRC | B_ROUT | B_ZIN, 12'h001, 1'b1);
        stepCheck("restart T5", IR_ADD, 1'b0, 1'b1, B_ZLOW | B_GRA | B_RIN, 12'h000, 1'b1);

        // halt parks the FSM with Run low.
        stepCheck("halt T0", IR_HALT, 1'b0, 1'b1, F_T0, 12'h000, 1'b1);
        stepCheck("halt T1", IR_HALT, 1'b0, 1'b1, F_T1, 12'h000, 1'b1);
        stepCheck("halt T2", IR_HALT, 1'b0, 1'b1, F_T2, 12'h000, 1'b1);
        stepCheck("halt T3", IR_HALT, 1'b0, 1'b1, 21'h0, 12'h000, 1'b1);
        for (int i = 0; i < 20; i++)
            stepCheck("halted", IR_ADD, 1'b0, 1'b1, 21'h0, 12'h000, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
